// File: rtl/sync_pkg.sv
// ----------------------------------------------------------------------------
// sync_pkg
// Shared definitions for the synchronizer-channel arbiter:
//   - FSM state type and encodings (IDLE / HOLD / GAP)
//   - Minimum legal values of the block parameters
//   - Width helpers for the channel index and the hold/gap counter
// No ports (package).
// ----------------------------------------------------------------------------
package sync_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HOLD = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    localparam int MIN_NUM_REQ     = 2;
    localparam int MIN_HOLD_CYCLES = 1;
    localparam int MIN_GAP_CYCLES  = 1;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter must hold the larger of the two phase lengths.
    function automatic int cnt_width(input int hold, input int gap);
        return $clog2(((hold > gap) ? hold : gap) + 1);
    endfunction

endpackage

// File: rtl/sync_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// sync_bus_arbiter_if
// Requester-side and synchronizer-side signals of the arbiter.
//   req        requester level requests            (master -> slave)
//   req_data   requester i word at [i*WIDTH +: WIDTH] (master -> slave)
//   ack        one-cycle "word taken" pulse         (slave -> master)
//   bus_en     level enable to the synchronizer     (slave -> master)
//   unsync_bus data to the synchronizer             (slave -> master)
//   ch_id      index of the channel in flight       (slave -> master)
//   busy       arbiter not idle                     (slave -> master)
// The arbiter connects through the slave modport.
// ----------------------------------------------------------------------------
interface sync_bus_arbiter_if
    import sync_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
) ();

    localparam int IW = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       ack;
    logic                     bus_en;
    logic [WIDTH-1:0]         unsync_bus;
    logic [IW-1:0]            ch_id;
    logic                     busy;

    modport master (
        output req, req_data,
        input  ack, bus_en, unsync_bus, ch_id, busy
    );

    modport slave (
        input  req, req_data,
        output ack, bus_en, unsync_bus, ch_id, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: combinational one-hot grant, scanning upward from the
// pointer with wrap, plus the pointer register. When update_en is high the
// pointer moves to one past the granted index.
//   clk        clock
//   rst        synchronous reset, active-high (pointer -> 0)
//   req_i      request vector
//   update_en  advance pointer past the current grant
//   grant_o    one-hot grant (zero when no request)
//   idx_o      binary index of grant_o
// ----------------------------------------------------------------------------
module rr_arbiter
    import sync_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          update_en,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] pos;
    logic          found;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = '0;
        for (int k = 0; k < N; k++) begin
            pos = IW'((int'(ptr_q) + k) % N);
            if (!found && req_i[pos]) begin
                found        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = pos;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_en) begin
            ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sync_bus_arbiter.sv
// ----------------------------------------------------------------------------
// sync_bus_arbiter
// Shares one level-enable synchronizer channel among NUM_REQ requesters.
// Each transfer: grant (round-robin), then bus_en high for HOLD_CYCLES, then
// low for GAP_CYCLES, with unsync_bus held stable until the next grant, so
// the destination sees exactly one rising edge of bus_en per word.
//   clk  source-domain clock
//   rst  synchronous reset, active-high
//   bus  slave side of sync_bus_arbiter_if (req/req_data in; ack, bus_en,
//        unsync_bus, ch_id, busy out -- all outputs registered)
// ----------------------------------------------------------------------------
module sync_bus_arbiter
    import sync_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                clk,
    input  logic                rst,
    sync_bus_arbiter_if.slave   bus
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);

    if (NUM_REQ < MIN_NUM_REQ) begin : g_bad_num_req
        $error("sync_bus_arbiter: NUM_REQ must be >= %0d", MIN_NUM_REQ);
    end
    if (HOLD_CYCLES < MIN_HOLD_CYCLES) begin : g_bad_hold
        $error("sync_bus_arbiter: HOLD_CYCLES must be >= %0d", MIN_HOLD_CYCLES);
    end
    if (GAP_CYCLES < MIN_GAP_CYCLES) begin : g_bad_gap
        $error("sync_bus_arbiter: GAP_CYCLES must be >= %0d", MIN_GAP_CYCLES);
    end

    state_t             state_q,  state_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [NUM_REQ-1:0] ack_q,    ack_d;
    logic               bus_en_q, bus_en_d;
    logic [WIDTH-1:0]   data_q,   data_d;
    logic [IW-1:0]      ch_id_q,  ch_id_d;
    logic               busy_q,   busy_d;

    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               grant_en;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.req),
        .update_en (grant_en),
        .grant_o   (grant),
        .idx_o     (grant_idx)
    );

    // The counter is loaded with (length - 1) on entry to HOLD/GAP and the
    // phase ends on the cycle it reads zero, giving exactly HOLD_CYCLES /
    // GAP_CYCLES cycles per phase. It holds in IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        bus_en_d = bus_en_q;
        data_d   = data_q;
        ch_id_d  = ch_id_q;
        grant_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    grant_en = 1'b1;
                    ack_d    = grant;
                    bus_en_d = 1'b1;
                    ch_id_d  = grant_idx;
                    cnt_d    = CW'(HOLD_CYCLES - 1);
                    state_d  = ST_HOLD;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant[i]) data_d = bus.req_data[i*WIDTH +: WIDTH];
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    bus_en_d = 1'b0;
                    cnt_d    = CW'(GAP_CYCLES - 1);
                    state_d  = ST_GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: begin
                bus_en_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ack_q    <= '0;
            bus_en_q <= 1'b0;
            data_q   <= '0;
            ch_id_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            bus_en_q <= bus_en_d;
            data_q   <= data_d;
            ch_id_q  <= ch_id_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.bus_en     = bus_en_q;
    assign bus.unsync_bus = data_q;
    assign bus.ch_id      = ch_id_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sync_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sync_bus_arbiter
// Directed bench for sync_bus_arbiter with NUM_REQ=4, WIDTH=8, HOLD=4, GAP=3,
// plus a random-word run through a destination 2-flop synchronizer model
// clocked three times faster than the source.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sync_bus_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int HOLD    = 4;
    localparam int GAP     = 3;
    localparam int NWORDS  = 100;

    logic clk  = 1'b0;
    logic dclk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    sync_bus_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus_if ();

    sync_bus_arbiter #(
        .WIDTH       (WIDTH),
        .NUM_REQ     (NUM_REQ),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Source period 12 ns, destination period 4 ns; edges never coincide.
    always #6 clk = ~clk;
    initial begin
        #1;
        forever #2 dclk = ~dclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Destination synchronizer model: 2-flop sync + rising-edge detect; each
    // detected edge captures unsync_bus and is matched against the scoreboard.
    logic       mon_en = 1'b0;
    logic [7:0] exp_q[$];
    int         pulses = 0;

    initial begin : dest_model
        logic s1, s2, s3;
        logic [7:0] w;
        s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
        forever begin
            @(posedge dclk);
            if (mon_en && s2 && !s3) begin
                pulses++;
                w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                check("dst_word", 32'(bus_if.unsync_bus), 32'(w));
            end
            s3 = s2;
            s2 = s1;
            s1 = bus_if.bus_en;
        end
    end

    logic [7:0] src_q[NUM_REQ][$];
    int         acks;
    int         exp_ch;

    initial begin
        // 1. reset with all requests high
        rst             = 1'b1;
        bus_if.req      = 4'hF;
        bus_if.req_data = 32'h44332211;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_bus_en", 32'(bus_if.bus_en),     0);
            check("rst_ack",    32'(bus_if.ack),        0);
            check("rst_data",   32'(bus_if.unsync_bus), 0);
            check("rst_busy",   32'(bus_if.busy),       0);
            check("rst_ch_id",  32'(bus_if.ch_id),      0);
        end

        // 2. single request on channel 1 for one cycle
        rst             = 1'b0;
        bus_if.req      = 4'b0010;
        bus_if.req_data = 32'h4433A511;
        step();
        check("t2_ack",    32'(bus_if.ack),        32'h2);
        check("t2_bus_en", 32'(bus_if.bus_en),     1);
        check("t2_data",   32'(bus_if.unsync_bus), 32'hA5);
        check("t2_ch_id",  32'(bus_if.ch_id),      1);
        check("t2_busy",   32'(bus_if.busy),       1);
        bus_if.req = 4'b0000;
        for (int k = 2; k <= 8; k++) begin
            step();
            check("t2_ack_low", 32'(bus_if.ack),        0);
            check("t2_bus_en",  32'(bus_if.bus_en),     (k <= HOLD) ? 1 : 0);
            check("t2_busy",    32'(bus_if.busy),       (k <= HOLD + GAP) ? 1 : 0);
            check("t2_data",    32'(bus_if.unsync_bus), 32'hA5);
        end

        // 3. pointer back to 0, all requesters held: strict rotation 0,1,2,3,0
        rst = 1'b1;
        step();
        rst        = 1'b0;
        bus_if.req = 4'hF;
        for (int k = 1; k <= 40; k++) begin
            step();
            exp_ch = ((k - 1) / 8) % NUM_REQ;
            check("t3_ack",    32'(bus_if.ack), ((k - 1) % 8 == 0) ? (1 << exp_ch) : 0);
            check("t3_ch_id",  32'(bus_if.ch_id), exp_ch);
            check("t3_bus_en", 32'(bus_if.bus_en), ((k - 1) % 8 < HOLD) ? 1 : 0);
            if (k == 40) bus_if.req = 4'h0;
        end

        // 4. data changes after ack are ignored (pointer now 1, only req[2])
        bus_if.req      = 4'b0100;
        bus_if.req_data = 32'h443C2211;
        step();
        check("t4_ack",  32'(bus_if.ack),        32'h4);
        check("t4_data", 32'(bus_if.unsync_bus), 32'h3C);
        bus_if.req      = 4'b0000;
        bus_if.req_data = 32'h44FF2211;
        for (int k = 2; k <= 10; k++) begin
            step();
            check("t4_data_hold", 32'(bus_if.unsync_bus), 32'h3C);
        end
        check("t4_idle", 32'(bus_if.busy), 0);

        // 5. reset in the 2nd HOLD cycle of a channel-3 grant (pointer now 3)
        bus_if.req = 4'b1000;
        step();
        check("t5_ack", 32'(bus_if.ack), 32'h8);
        bus_if.req = 4'b0000;
        step();
        check("t5_hold", 32'(bus_if.bus_en), 1);
        rst = 1'b1;
        step();
        check("t5_rst_bus_en", 32'(bus_if.bus_en), 0);
        check("t5_rst_busy",   32'(bus_if.busy),   0);
        check("t5_rst_ack",    32'(bus_if.ack),    0);
        check("t5_rst_ch_id",  32'(bus_if.ch_id),  0);
        rst        = 1'b0;
        bus_if.req = 4'hF;
        step();
        check("t5_regrant_ack",   32'(bus_if.ack),   32'h1);
        check("t5_regrant_ch_id", 32'(bus_if.ch_id), 0);
        bus_if.req = 4'h0;
        for (int k = 0; k < 7; k++) step();
        check("t5_idle", 32'(bus_if.busy), 0);

        // 6. random words through the destination synchronizer model
        for (int w = 0; w < NWORDS; w++) src_q[w % NUM_REQ].push_back(8'($urandom_range(0, 255)));
        mon_en = 1'b1;
        acks   = 0;
        for (int cyc = 0; cyc < 3000 && acks < NWORDS; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                bus_if.req[i] = (src_q[i].size() != 0) && ($urandom_range(0, 3) != 0);
                if (src_q[i].size() != 0) bus_if.req_data[i*WIDTH +: WIDTH] = src_q[i][0];
            end
            step();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus_if.ack[i]) begin
                    acks++;
                    exp_q.push_back((src_q[i].size() != 0) ? src_q[i].pop_front() : 8'hxx);
                end
            end
        end
        bus_if.req = 4'h0;
        for (int k = 0; k < 30; k++) step();
        check("t6_acks",    acks,         NWORDS);
        check("t6_pulses",  pulses,       NWORDS);
        check("t6_pending", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
